// File: rtl/ram_readback_checker.sv
// Read-side checker for one port of the 8-bit dual-port RAM: sweeps an address window and compares each byte against addr*mult.
// Build option CHK_STOP_ON_ERR_EN: stop issuing reads at the first mismatch, then drain the reads already in flight.
module ram_readback_checker #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int RD_LATENCY = 1,
  parameter int ECW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  input  logic [DW-1:0] mult,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          done,
  output logic [ECW-1:0] err_count,
  output logic          first_err_valid,
  output logic [AW-1:0] first_err_addr
);

  // state   | meaning
  // IDLE    | waiting for start; results of the last sweep held
  // ISSUE   | one read per cycle until the window is exhausted
  // DRAIN   | waiting for reads still in flight to be compared
  // FIN     | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] cur_addr;
  logic [AW:0]   remaining;
  logic [DW-1:0] mult_q;

  // Stage 0 is the issue register that drives ram_addr; stages 1..RD_LATENCY are the delay line.
  logic [RD_LATENCY:0] st_v;
  logic [AW-1:0]       st_addr [RD_LATENCY+1];
  logic [DW-1:0]       st_exp  [RD_LATENCY+1];

  logic          issue;
  logic [AW-1:0] issue_addr;
  logic [DW-1:0] issue_mult;
  logic          accept;
  logic          mismatch;
  logic          stop;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] m);
    logic [AW+DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{AW{1'b0}}, m};
    return p[DW-1:0];
  endfunction

  assign ram_we   = 1'b0;
  assign ram_addr = st_addr[0];
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);
  assign accept   = (state == S_IDLE) && start;
  assign mismatch = st_v[RD_LATENCY] && (ram_rdata != st_exp[RD_LATENCY]);

`ifdef CHK_STOP_ON_ERR_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = cur_addr;
    issue_mult = mult_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_nxt = S_FIN;
          end else begin
            // first read goes out on the start edge so ram_addr is valid the next cycle
            state_nxt  = S_ISSUE;
            issue      = 1'b1;
            issue_addr = base_addr;
            issue_mult = mult;
          end
        end
      end
      S_ISSUE: begin
        if (remaining == '0 || stop) begin
          state_nxt = S_DRAIN;
        end else begin
          issue = 1'b1;
          if (remaining == (AW+1)'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (st_v == '0) state_nxt = S_FIN;
      end
      S_FIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cur_addr        <= '0;
      remaining       <= '0;
      mult_q          <= '0;
      st_v            <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        st_addr[i] <= '0;
        st_exp[i]  <= '0;
      end
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      state   <= state_nxt;
      st_v[0] <= issue;
      if (issue) begin
        st_addr[0] <= issue_addr;
        st_exp[0]  <= pattern(issue_addr, issue_mult);
        cur_addr   <= issue_addr + AW'(1);
      end
      if (accept) begin
        mult_q    <= mult;
        remaining <= count - (AW+1)'(1);
      end else if (issue) begin
        remaining <= remaining - (AW+1)'(1);
      end
      for (int i = 1; i <= RD_LATENCY; i++) begin
        st_v[i]    <= st_v[i-1];
        st_addr[i] <= st_addr[i-1];
        st_exp[i]  <= st_exp[i-1];
      end
      if (accept) begin
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
      end else if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ECW'(1);
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= st_addr[RD_LATENCY];
        end
      end
    end
  end

endmodule
